// File: rtl/wlser_pkg.sv
// Shared types and helpers for the word-to-lane serializer and its up-converter sibling.
package wlser_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic int lanes(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // A usable geometry splits the word evenly into at least two lanes.
  function automatic bit cfg_ok(input int in_w, input int out_w);
    return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2);
  endfunction

endpackage

// File: rtl/word_lane_serializer_lane_select.sv
// Combinational lane picker: returns data[idx*OUT_W +: OUT_W].
module lane_select #(
  parameter  int IN_W  = 32,
  parameter  int OUT_W = 8,
  localparam int N     = IN_W / OUT_W,
  localparam int CW    = $clog2(N)
) (
  input  logic [IN_W-1:0]  data,
  input  logic [CW-1:0]    idx,
  output logic [OUT_W-1:0] lane
);

  // Explicit mux avoids a variable-offset shifter and stays clean for non-power-of-two N.
  always_comb begin
    lane = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(idx) == k) lane = data[k*OUT_W +: OUT_W];
    end
  end

endmodule

// File: rtl/word_lane_serializer.sv
// Word-to-lane down-converter: one IN_W word in, s_cnt+1 OUT_W lanes out in selectable order.
module word_lane_serializer
  import wlser_pkg::*;
#(
  parameter  int IN_W  = 32,
  parameter  int OUT_W = 8,
  localparam int N     = lanes(IN_W, OUT_W),
  localparam int CW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic [CW-1:0]    s_cnt,
  input  logic             s_msb_first,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [CW-1:0]    m_idx,
  output logic             m_last
);

  if (!cfg_ok(IN_W, OUT_W)) begin : g_cfg_check
    $fatal(1, "word_lane_serializer: IN_W must be a multiple of OUT_W with at least two lanes");
  end

  state_t          state_q;
  logic [IN_W-1:0] word_q;
  logic [CW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;
  logic            msb_q;
  logic            accept;
  logic            xfer;

  lane_select #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_lane_select (
    .data(word_q),
    .idx (idx_q),
    .lane(m_data)
  );

  assign m_valid = (state_q == SEND);
  assign m_idx   = idx_q;
  assign m_last  = (state_q == SEND) && (idx_q == (msb_q ? '0 : cnt_q));
  assign xfer    = m_valid && m_ready;
  // Ready on the final lane lets the next word load with no bubble.
  assign s_ready = (state_q == IDLE) || (xfer && m_last);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
    end else if (accept) begin
      state_q <= SEND;
      word_q  <= s_data;
      cnt_q   <= s_cnt;
      msb_q   <= s_msb_first;
      idx_q   <= s_msb_first ? s_cnt : '0;
    end else if (xfer) begin
      if (m_last) state_q <= IDLE;
      else        idx_q   <= msb_q ? idx_q - CW'(1) : idx_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_word_lane_serializer.sv
// Randomised and directed bench for word_lane_serializer against a lane-queue reference model.
module tb_word_lane_serializer;

  localparam int IN_W  = 32;
  localparam int OUT_W = 8;

  typedef struct {
    logic [7:0] data;
    logic [1:0] idx;
    logic       last;
  } lane_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [1:0]  s_cnt = '0;
  logic        s_msb_first = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic [1:0]  m_idx;
  logic        m_last;

  int    n_checks = 0;
  int    n_pass = 0;
  int    rdy_mode = 0;
  int    cyc = 0;
  lane_t exp_q[$];

  word_lane_serializer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_cnt      (s_cnt),
    .s_msb_first(s_msb_first),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_idx      (m_idx),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: a word becomes an ordered list of lanes; the block holds at most one word.
  task automatic push_word(input logic [31:0] d, input int c, input bit msb);
    for (int i = 0; i <= c; i++) begin
      lane_t e;
      int    ln;
      ln     = msb ? c - i : i;
      e.data = 8'((d >> (ln * 8)) & 32'hff);
      e.idx  = 2'(ln);
      e.last = (i == c);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic pick_ready();
    case (rdy_mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One clock: inputs driven just after posedge, everything checked at negedge.
  task automatic step(input logic v, input logic [31:0] d, input logic [1:0] c,
                      input logic msb, output bit acc);
    bit exp_rdy;
    bit xfer;
    s_valid     = v;
    s_data      = d;
    s_cnt       = c;
    s_msb_first = msb;
    m_ready     = pick_ready();
    cyc++;
    @(negedge clk);
    check("m_valid", m_valid, exp_q.size() != 0);
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && m_ready);
    check("s_ready", s_ready, exp_rdy);
    if (exp_q.size() != 0) begin
      check("m_data", m_data, exp_q[0].data);
      check("m_idx", m_idx, exp_q[0].idx);
      check("m_last", m_last, exp_q[0].last);
    end else begin
      check("m_last_idle", m_last, 1'b0);
    end
    xfer = (exp_q.size() != 0) && m_ready;
    acc  = v && exp_rdy;
    if (xfer) void'(exp_q.pop_front());
    if (acc) push_word(d, int'(c), msb);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [1:0] c, input logic msb);
    bit acc;
    int n = 0;
    do begin
      step(1'b1, d, c, msb, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) check("accept_timeout", 32'(n), 32'd0);
  endtask

  task automatic idle_cycles(input int k);
    bit acc;
    for (int i = 0; i < k; i++) step(1'b0, 32'h0, 2'd0, 1'b0, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idle_cycles(1);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    idle_cycles(1);
  endtask

  initial begin
    bit acc;
    #3;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_idx", m_idx, 2'd0);
    check("rst_m_last", m_last, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    rdy_mode = 0;
    send_word(32'hdeadbeaf, 2'd3, 1'b0);
    drain();
    send_word(32'hdeadbeaf, 2'd3, 1'b1);
    drain();
    send_word(32'hdeadbeaf, 2'd1, 1'b0);
    drain();
    send_word(32'hdeadbeaf, 2'd0, 1'b1);
    drain();

    send_word(32'hdeadbeaf, 2'd3, 1'b0);
    send_word(32'h01234567, 2'd3, 1'b0);
    drain();

    rdy_mode = 1;
    cyc = 0;
    send_word(32'hdeadbeaf, 2'd3, 1'b0);
    send_word(32'hcafef00d, 2'd2, 1'b1);
    drain();

    // Asynchronous reset after two lanes of a word have gone out.
    rdy_mode = 0;
    send_word(32'hdeadbeaf, 2'd3, 1'b0);
    idle_cycles(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_s_ready", s_ready, 1'b1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(32'h11223344, 2'd3, 1'b0);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/word_lane_serializer.md
# word_lane_serializer

Parametrised word-to-lane down-converter: accepts an IN_W-bit word on a valid/ready slave port and emits it as a sequence of OUT_W-bit lanes on a valid/ready master port, one lane per accepted beat. It generalises our fixed 32-to-8 byte split by adding configurable widths, a per-word lane count and a per-word lane order. It sits between wide internal datapaths and narrow byte-oriented sinks such as a UART TX, an SPI shifter or a debug trace port.

## Interface
- IN_W, default 32: input word width; must be an integer multiple of OUT_W.
- OUT_W, default 8: output lane width.
- N (localparam) = IN_W/OUT_W: lanes per word; must be ≥ 2.
- CW (localparam) = $clog2(N): lane index/count width.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- s_valid  input  1  input word valid.
- s_ready  output  1  block can accept a word this cycle.
- s_data  input  IN_W  input word; lane k is s_data[k*OUT_W +: OUT_W].
- s_cnt  input  CW  number of lanes to emit, minus 1 (0 → 1 lane, N-1 → all lanes).
- s_msb_first  input  1  0: emit lanes 0..s_cnt ascending; 1: emit lanes s_cnt..0 descending.
- m_valid  output  1  output lane valid.
- m_ready  input  1  sink accepts lane.
- m_data  output  OUT_W  current lane.
- m_idx  output  CW  lane index of m_data within the word.
- m_last  output  1  high on the final lane of the word.

## Operation
- Two states: IDLE (no word held) and SEND (word held, lanes pending).
- Word accept: s_valid && s_ready. Captures s_data, s_cnt and s_msb_first into registers, sets the first lane index (0 for LSB-first, s_cnt for MSB-first), and enters SEND.
- In SEND: m_valid=1, m_data = word_q[idx_q*OUT_W +: OUT_W], m_idx = idx_q, m_last = (idx_q == end index), where end index is s_cnt for LSB-first and 0 for MSB-first.
- Lane transfer: m_valid && m_ready. If not last, idx_q steps by +1 for LSB-first or -1 for MSB-first. If last, the word is complete.
- s_ready = (state==IDLE) || (m_valid && m_ready && m_last). This is combinational from m_ready and allows zero-bubble back-to-back words.
- On a completing last lane:
  - with a simultaneous accept, load the new word and stay in SEND;
  - otherwise go to IDLE.
- m_data, m_idx and m_last are held stable while m_valid && !m_ready. s_data is ignored when no accept occurs.
- Lanes above s_cnt are never emitted.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE; word_q, idx_q and config registers cleared. Outputs: m_valid=0, m_data=0, m_idx=0, m_last=0, s_ready=1 (combinational from IDLE).
- Latency: word accepted at edge t; first lane has m_valid=1 in the cycle after t.
- Throughput with m_ready held high: one lane per cycle, s_cnt+1 cycles per word, no idle cycle between consecutive words.
- Reset mid-word discards all pending lanes. The first cycle after rst_n deasserts is IDLE with s_ready=1.
- m_ready low on the last lane blocks s_ready, so no word is lost or overwritten.
- s_cnt=0: a single lane with m_last=1. For MSB-first this is lane 0.

## Structure
- Package wlser_pkg:
  - function lanes(in_w, out_w);
  - state enum {IDLE, SEND};
  - elaboration check that IN_W%OUT_W==0 and N≥2, with $fatal otherwise.
- Sub-module lane_select (params IN_W, OUT_W): combinational indexed part select, data[idx*OUT_W +: OUT_W]. Reusable by the matching up-converter.
- Top level holds the FSM, lane counter and handshake logic.

## Test plan
- IN_W=32, OUT_W=8, s_data=32'hdeadbeaf, s_cnt=3, s_msb_first=0, m_ready=1 -> m_data af,be,ad,de on 4 consecutive cycles; m_idx 0,1,2,3; m_last only on de.
- Same word with s_msb_first=1 -> de,ad,be,af; m_idx 3,2,1,0; m_last on af.
- s_cnt=1, LSB-first -> af,be only; m_last on be; returns to IDLE, s_ready=1 the next cycle.
- Two words (deadbeaf, then 01234567) offered back-to-back with m_ready=1 -> 8 contiguous lanes af,be,ad,de,67,45,23,01 with no gap; s_ready pulses high with the first m_last.
- m_ready toggled 1,0,0,1,... during deadbeaf -> every lane emitted exactly once, m_data held stable while stalled, s_ready=0 until the last lane transfers.
- rst_n pulsed low after the second lane of deadbeaf -> m_valid=0 immediately, then s_ready=1; next word 11223344 emits 44,33,22,11 with no residue of the old word.
